hazard_stall_controller: RTL and testbench

// - Pipeline sequencing controller for the 5-stage RV32 core; companion to the EX-stage operand forwarding logic.
// - Generates PC/IF-ID/ID-EX/EX-MEM write enables, bubbles and flushes.
// - Handles load-use stalls, taken-branch flushes, data-memory wait states and multi-cycle mul/div occupancy.
// - Sits beside the decode stage; consumes ID/EX/MEM hazard info; drives all pipeline-register control.

---
 rtl/hazard_pkg.sv | 10 +
 rtl/hazard_perf_counter.sv | 13 +
 rtl/hazard_stall_controller.sv | 78 +++++++
 tb/tb_hazard_stall_controller.sv | 104 ++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and constants for the pipeline hazard/stall controller
package hazard_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MULDIV   = 2'd2
  } state_t;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [4:0]  REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_perf_counter.sv
// hazard_perf_counter: CNT_W-bit enabled counter that wraps modulo 2^CNT_W
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: 5-stage pipeline stall/flush/bubble sequencing with mul/div watchdog
// Optional stall/flush performance counters enabled by defining HAZARD_STALL_COUNTERS_EN.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MULDIV_TIMEOUT = 40,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             branch_taken_ex,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             muldiv_start,
  input  logic             muldiv_done,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             muldiv_abort,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int TO_W = $clog2(MULDIV_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MULDIV_TIMEOUT - 1);
  state_t state;
  logic [TO_W-1:0] to_cnt;
  logic load_use, mem_stall, md_issue, timeout, freeze, run_ok, flush, lu;
  assign load_use  = idex_memread & (idex_rd != REG_ZERO) & (idex_rd == rs1_id | idex_rd == rs2_id);
  assign mem_stall = state == RUN & dmem_req & !dmem_ack;
  assign md_issue  = state == RUN & !mem_stall & muldiv_start;
  assign timeout   = state == MULDIV & !muldiv_done & to_cnt == TO_LAST;
  assign freeze    = mem_stall | md_issue | (state == MEM_WAIT & !dmem_ack)
                   | (state == MULDIV & !muldiv_done & !timeout);
  assign run_ok    = state == RUN & !freeze;
  // a taken branch squashes the ID instruction, so any load-use hazard on it is moot
  assign flush     = run_ok & branch_taken_ex;
  assign lu        = run_ok & !branch_taken_ex & load_use;
  assign pc_we        = !rst & !freeze & !lu;
  assign ifid_we      = !rst & !freeze & !lu;
  assign exmem_we     = !rst & !freeze;
  assign ifid_flush   = rst | flush;
  assign idex_bubble  = rst | flush | lu;
  assign muldiv_abort = !rst & timeout;
  always_ff @(posedge clk)
    if (rst) begin
      state  <= RUN;
      to_cnt <= '0;
    end else begin
      state  <= mem_stall ? MEM_WAIT :
                md_issue ? MULDIV :
                (state == MEM_WAIT & !dmem_ack) ? MEM_WAIT :
                (state == MULDIV & !muldiv_done & !timeout) ? MULDIV : RUN;
      to_cnt <= state == MULDIV ? to_cnt + 1'b1 : '0;
    end
`ifdef HAZARD_STALL_COUNTERS_EN
  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (!pc_we & !rst),
    .cnt (stall_cnt)
  );
  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (ifid_flush & !rst),
    .cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: table-driven and sequence checks of the hazard/stall controller
module tb_hazard_stall_controller;
  typedef struct packed {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       mr;
    logic [4:0] rd;
    logic       br, req, ack, ms, md;
    logic [5:0] exp;
  } vec_t;
  // expected {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, muldiv_abort}
  localparam logic [5:0] NORM = 6'b110010;
  localparam logic [5:0] LU   = 6'b000110;
  localparam logic [5:0] FRZ  = 6'b000000;
  localparam logic [5:0] FL   = 6'b111110;
  localparam logic [5:0] RSTV = 6'b001100;
  localparam logic [5:0] AB   = 6'b110011;
  logic clk = 0, rst = 1;
  logic [4:0] rs1_id = 0, rs2_id = 0, idex_rd = 0;
  logic idex_memread = 0, branch_taken_ex = 0, dmem_req = 0, dmem_ack = 0, muldiv_start = 0, muldiv_done = 0;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, muldiv_abort;
  logic [31:0] stall_cnt, flush_cnt;
  int total = 0, bad = 0;
  vec_t tbl [20];
  always #5 clk = ~clk;
  hazard_stall_controller #(.MULDIV_TIMEOUT(40), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .idex_memread(idex_memread),
    .idex_rd(idex_rd), .branch_taken_ex(branch_taken_ex), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .muldiv_start(muldiv_start), .muldiv_done(muldiv_done), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_we(exmem_we),
    .muldiv_abort(muldiv_abort), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  function automatic vec_t mk(logic r, logic [4:0] s1, logic [4:0] s2, logic m, logic [4:0] d,
                              logic b, logic q, logic a, logic st, logic dn, logic [5:0] e);
    return '{rst:r, rs1:s1, rs2:s2, mr:m, rd:d, br:b, req:q, ack:a, ms:st, md:dn, exp:e};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic apply(input vec_t v, input string name);
    rst = v.rst; rs1_id = v.rs1; rs2_id = v.rs2; idex_memread = v.mr; idex_rd = v.rd;
    branch_taken_ex = v.br; dmem_req = v.req; dmem_ack = v.ack; muldiv_start = v.ms; muldiv_done = v.md;
    @(negedge clk);
    chk(name, {26'd0, pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, muldiv_abort}, {26'd0, v.exp});
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cnt(input string name, input logic [31:0] s, input logic [31:0] f);
`ifdef HAZARD_STALL_COUNTERS_EN
    chk({name, "_stall"}, stall_cnt, s);
    chk({name, "_flush"}, flush_cnt, f);
`else
    chk({name, "_stall"}, stall_cnt, 32'd0 & s);
    chk({name, "_flush"}, flush_cnt, 32'd0 & f);
`endif
  endtask
  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV);
    tbl[1]  = mk(0, 1, 2, 0, 3, 0, 0, 0, 0, 0, NORM);
    tbl[2]  = mk(0, 5, 6, 1, 5, 0, 0, 0, 0, 0, LU);
    tbl[3]  = mk(0, 5, 6, 0, 0, 0, 0, 0, 0, 0, NORM);
    tbl[4]  = mk(0, 3, 7, 1, 7, 0, 0, 0, 0, 0, LU);
    tbl[5]  = mk(0, 0, 4, 1, 0, 0, 0, 0, 0, 0, NORM);
    tbl[6]  = mk(0, 5, 6, 1, 5, 1, 0, 0, 0, 0, FL);
    tbl[7]  = mk(0, 1, 2, 0, 3, 1, 0, 0, 0, 0, FL);
    tbl[8]  = mk(0, 1, 2, 0, 3, 0, 1, 1, 0, 0, NORM);
    tbl[9]  = mk(0, 1, 2, 0, 3, 0, 1, 0, 0, 0, FRZ);
    tbl[10] = mk(0, 1, 2, 0, 3, 1, 1, 0, 0, 0, FRZ);
    tbl[11] = mk(0, 1, 2, 0, 3, 0, 1, 0, 0, 0, FRZ);
    tbl[12] = mk(0, 1, 2, 0, 3, 0, 1, 1, 0, 0, NORM);
    tbl[13] = mk(0, 1, 2, 0, 3, 0, 1, 0, 1, 0, FRZ);
    tbl[14] = mk(0, 1, 2, 0, 3, 0, 1, 1, 0, 0, NORM);
    tbl[15] = mk(0, 1, 2, 0, 3, 0, 0, 0, 0, 0, NORM);
    tbl[16] = mk(0, 1, 2, 0, 3, 0, 0, 0, 1, 0, FRZ);
    tbl[17] = mk(0, 5, 6, 1, 5, 1, 0, 0, 0, 0, FRZ);
    tbl[18] = mk(0, 1, 2, 0, 3, 0, 0, 0, 0, 1, NORM);
    tbl[19] = mk(0, 9, 6, 1, 9, 0, 0, 0, 0, 0, LU);
    #1;
    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("vec%0d", i));
    // watchdog: start cycle, 39 frozen MULDIV cycles, abort in the 40th
    apply(mk(0, 1, 2, 0, 3, 0, 0, 0, 1, 0, FRZ), "wd_start");
    for (int i = 0; i < 39; i++) apply(mk(0, 1, 2, 0, 3, 0, 0, 0, 0, 0, FRZ), $sformatf("wd_frz%0d", i));
    apply(mk(0, 1, 2, 0, 3, 0, 0, 0, 0, 0, AB), "wd_abort");
    apply(mk(0, 1, 2, 0, 3, 0, 0, 0, 0, 0, NORM), "wd_after");
    // reset in the middle of a mul/div: no abort, RUN immediately after
    apply(mk(0, 1, 2, 0, 3, 0, 0, 0, 1, 0, FRZ), "rm_start");
    for (int i = 0; i < 4; i++) apply(mk(0, 1, 2, 0, 3, 0, 0, 0, 0, 0, FRZ), $sformatf("rm_frz%0d", i));
    apply(mk(1, 1, 2, 0, 3, 0, 0, 0, 0, 0, RSTV), "rm_rst");
    chk_cnt("cnt_rst", 0, 0);
    apply(mk(0, 5, 2, 1, 5, 0, 0, 0, 0, 0, LU), "rm_run_lu");
    apply(mk(0, 1, 2, 0, 3, 1, 0, 0, 0, 0, FL), "rm_br");
    chk_cnt("cnt_after", 1, 1);
    apply(mk(0, 1, 2, 0, 3, 0, 1, 0, 0, 0, FRZ), "cnt_mw0");
    apply(mk(0, 1, 2, 0, 3, 0, 1, 0, 0, 0, FRZ), "cnt_mw1");
    apply(mk(0, 1, 2, 0, 3, 0, 1, 1, 0, 0, NORM), "cnt_mw_ack");
    chk_cnt("cnt_mw", 3, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
